// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one downstream memory port between the instruction-fetch
// channel and the data load/store channel. One requester holds the grant from
// request to response; at most one transaction is outstanding downstream.
module mem_arbiter #(
   parameter bit DATA_PRIO = 1'b1   // 1: data wins a tie; 0: round-robin
) (
   input  logic        clk,
   input  logic        rst,            // asynchronous, active-low

   input  logic [31:0] i_inst_req_addr,
   input  logic        i_inst_req_valid,
   output logic        o_inst_req_ready,
   output logic [31:0] o_inst_rdata,
   output logic        o_inst_rvalid,
   input  logic        i_inst_rready,

   input  logic [31:0] i_data_addr,
   input  logic        i_data_rd,
   input  logic        i_data_wr,
   input  logic [31:0] i_data_wdata,
   input  logic [3:0]  i_data_wstrb,
   output logic        o_data_req_ready,
   output logic [31:0] o_data_rdata,
   output logic        o_data_rvalid,
   input  logic        i_data_rready,

   output logic [31:0] o_mem_addr,
   output logic        o_mem_wen,
   output logic [31:0] o_mem_wdata,
   output logic [3:0]  o_mem_wstrb,
   output logic        o_mem_req_valid,
   input  logic        i_mem_req_ready,
   input  logic [31:0] i_mem_rdata,
   input  logic        i_mem_rvalid,
   output logic        o_mem_rready
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t r_state;
   logic   r_gnt_data;        // 1: data channel owns the grant
   logic   r_last_gnt_data;   // requester served most recently (1 = data)
   logic   r_mem_req_valid;   // registered copy of "in REQ"
   logic   r_in_resp;         // registered copy of "in RESP"

   logic   w_data_req;
   logic   w_pick_data;
   logic   w_gnt_wr;
   logic   w_sel_data_req;

   // A data request is a load or a store; a store wins if both are raised.
   assign w_data_req = i_data_rd | i_data_wr;
   assign w_gnt_wr   = r_gnt_data & i_data_wr;

   // Arbitration: who would be granted if the grant were taken this cycle.
   always_comb begin
      // NOTE: default first so every path assigns the output and no latch is inferred.
      w_pick_data = w_data_req;
      if (w_data_req && i_inst_req_valid) begin
         w_pick_data = DATA_PRIO ? 1'b1 : ~r_last_gnt_data;
      end
   end

   // Grant FSM: IDLE -> REQ -> (RESP for reads) -> IDLE, with registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
         r_state         <= S_IDLE;
         r_gnt_data      <= 1'b0;
         r_last_gnt_data <= 1'b0;
         r_mem_req_valid <= 1'b0;
         r_in_resp       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_data_req || i_inst_req_valid) begin
                  r_gnt_data      <= w_pick_data;
                  r_last_gnt_data <= w_pick_data;
                  r_mem_req_valid <= 1'b1;
                  r_state         <= S_REQ;
               end
            end
            S_REQ: begin
               if (i_mem_req_ready) begin
                  r_mem_req_valid <= 1'b0;
                  if (w_gnt_wr) begin
                     r_gnt_data <= 1'b0;
                     r_state    <= S_IDLE;
                  end else begin
                     r_in_resp <= 1'b1;
                     r_state   <= S_RESP;
                  end
               end
            end
            S_RESP: begin
               if (i_mem_rvalid && o_mem_rready) begin
                  r_in_resp  <= 1'b0;
                  r_gnt_data <= 1'b0;
                  r_state    <= S_IDLE;
               end
            end
            default: begin
               r_in_resp       <= 1'b0;
               r_mem_req_valid <= 1'b0;
               r_gnt_data      <= 1'b0;
               r_state         <= S_IDLE;
            end
         endcase
      end
   end

   // Request path: fields are muxed from the granted requester and zeroed outside REQ.
   assign w_sel_data_req   = r_mem_req_valid & r_gnt_data;
   assign o_mem_req_valid  = r_mem_req_valid;
   assign o_mem_addr       = !r_mem_req_valid ? 32'd0 :
                             (r_gnt_data ? i_data_addr : i_inst_req_addr);
   assign o_mem_wen        = r_mem_req_valid & w_gnt_wr;
   assign o_mem_wdata      = o_mem_wen ? i_data_wdata : 32'd0;
   assign o_mem_wstrb      = o_mem_wen ? i_data_wstrb : 4'd0;
   assign o_inst_req_ready = r_mem_req_valid & ~r_gnt_data & i_mem_req_ready;
   assign o_data_req_ready = w_sel_data_req & i_mem_req_ready;

   // Response path: only the granted requester sees rvalid, and only in RESP.
   assign o_mem_rready  = r_in_resp & (r_gnt_data ? i_data_rready : i_inst_rready);
   assign o_inst_rvalid = r_in_resp & ~r_gnt_data & i_mem_rvalid;
   assign o_data_rvalid = r_in_resp &  r_gnt_data & i_mem_rvalid;
   assign o_inst_rdata  = i_mem_rdata;
   assign o_data_rdata  = i_mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter. Instance u_dut uses data
// priority; u_dut_rr uses round-robin and shares the same stimulus.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] inst_req_addr = '0;
   logic        inst_req_valid = 1'b0;
   logic        inst_rready = 1'b0;
   logic [31:0] data_addr = '0;
   logic        data_rd = 1'b0;
   logic        data_wr = 1'b0;
   logic [31:0] data_wdata = '0;
   logic [3:0]  data_wstrb = '0;
   logic        data_rready = 1'b0;
   logic        mem_req_ready = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        mem_rvalid = 1'b0;

   // priority instance outputs
   logic        inst_req_ready, inst_rvalid, data_req_ready, data_rvalid;
   logic [31:0] inst_rdata, data_rdata, mem_addr, mem_wdata;
   logic        mem_wen, mem_req_valid, mem_rready;
   logic [3:0]  mem_wstrb;

   // round-robin instance outputs
   logic        rr_inst_req_ready, rr_inst_rvalid, rr_data_req_ready, rr_data_rvalid;
   logic [31:0] rr_inst_rdata, rr_data_rdata, rr_mem_addr, rr_mem_wdata;
   logic        rr_mem_wen, rr_mem_req_valid, rr_mem_rready;
   logic [3:0]  rr_mem_wstrb;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.DATA_PRIO(1'b1)) u_dut (
      .clk(clk), .rst(rst),
      .i_inst_req_addr(inst_req_addr), .i_inst_req_valid(inst_req_valid),
      .o_inst_req_ready(inst_req_ready), .o_inst_rdata(inst_rdata),
      .o_inst_rvalid(inst_rvalid), .i_inst_rready(inst_rready),
      .i_data_addr(data_addr), .i_data_rd(data_rd), .i_data_wr(data_wr),
      .i_data_wdata(data_wdata), .i_data_wstrb(data_wstrb),
      .o_data_req_ready(data_req_ready), .o_data_rdata(data_rdata),
      .o_data_rvalid(data_rvalid), .i_data_rready(data_rready),
      .o_mem_addr(mem_addr), .o_mem_wen(mem_wen), .o_mem_wdata(mem_wdata),
      .o_mem_wstrb(mem_wstrb), .o_mem_req_valid(mem_req_valid),
      .i_mem_req_ready(mem_req_ready), .i_mem_rdata(mem_rdata),
      .i_mem_rvalid(mem_rvalid), .o_mem_rready(mem_rready)
   );

   mem_arbiter #(.DATA_PRIO(1'b0)) u_dut_rr (
      .clk(clk), .rst(rst),
      .i_inst_req_addr(inst_req_addr), .i_inst_req_valid(inst_req_valid),
      .o_inst_req_ready(rr_inst_req_ready), .o_inst_rdata(rr_inst_rdata),
      .o_inst_rvalid(rr_inst_rvalid), .i_inst_rready(inst_rready),
      .i_data_addr(data_addr), .i_data_rd(data_rd), .i_data_wr(data_wr),
      .i_data_wdata(data_wdata), .i_data_wstrb(data_wstrb),
      .o_data_req_ready(rr_data_req_ready), .o_data_rdata(rr_data_rdata),
      .o_data_rvalid(rr_data_rvalid), .i_data_rready(data_rready),
      .o_mem_addr(rr_mem_addr), .o_mem_wen(rr_mem_wen), .o_mem_wdata(rr_mem_wdata),
      .o_mem_wstrb(rr_mem_wstrb), .o_mem_req_valid(rr_mem_req_valid),
      .i_mem_req_ready(mem_req_ready), .i_mem_rdata(mem_rdata),
      .i_mem_rvalid(mem_rvalid), .o_mem_rready(rr_mem_rready)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance to the next falling edge; stimulus is applied there, checks 1 ns later.
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      inst_req_valid = 1'b0; inst_rready = 1'b0;
      data_rd = 1'b0; data_wr = 1'b0; data_rready = 1'b0;
      mem_req_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
   endtask

   task automatic check_quiet(input string tag);
      check({tag, " req_valid"}, {31'd0, mem_req_valid}, 32'd0);
      check({tag, " rready"}, {31'd0, mem_rready}, 32'd0);
      check({tag, " readies"}, {30'd0, inst_req_ready, data_req_ready}, 32'd0);
      check({tag, " rvalids"}, {30'd0, inst_rvalid, data_rvalid}, 32'd0);
      check({tag, " addr"}, mem_addr, 32'd0);
      check({tag, " wdata/wstrb/wen"}, {mem_wdata[26:0], mem_wstrb, mem_wen}, 32'd0);
   endtask

   // Complete one fetch from IDLE with an always-ready memory.
   task automatic do_fetch(input string tag, input logic [31:0] addr, input logic [31:0] insn);
      inst_req_addr = addr; inst_req_valid = 1'b1; mem_req_ready = 1'b1; inst_rready = 1'b1;
      #1;
      check({tag, " idle no valid"}, {31'd0, mem_req_valid}, 32'd0);
      check({tag, " idle no ready"}, {31'd0, inst_req_ready}, 32'd0);
      tick(); #1;
      check({tag, " req valid"}, {31'd0, mem_req_valid}, 32'd1);
      check({tag, " req addr"}, mem_addr, addr);
      check({tag, " req wen"}, {31'd0, mem_wen}, 32'd0);
      check({tag, " req ready"}, {31'd0, inst_req_ready}, 32'd1);
      tick();
      inst_req_valid = 1'b0; mem_rdata = insn; mem_rvalid = 1'b1; #1;
      check({tag, " resp rvalid"}, {31'd0, inst_rvalid}, 32'd1);
      check({tag, " resp rdata"}, inst_rdata, insn);
      check({tag, " resp rready"}, {31'd0, mem_rready}, 32'd1);
      check({tag, " resp no req_ready"}, {31'd0, inst_req_ready}, 32'd0);
      tick();
      mem_rvalid = 1'b0; #1;
      check_quiet({tag, " back idle"});
   endtask

   initial begin
      logic exp_order [4];
      exp_order = '{1'b1, 1'b0, 1'b1, 1'b0};

      // Reset state
      tick(); #1;
      check_quiet("reset");
      tick();
      rst = 1'b1;

      // Fetch only
      do_fetch("fetch", 32'h100, 32'h0000_0013);

      // Store: one REQ cycle, no RESP
      data_wr = 1'b1; data_addr = 32'h200; data_wdata = 32'hDEAD_BEEF; data_wstrb = 4'b0011;
      mem_req_ready = 1'b1;
      tick(); #1;
      check("store valid", {31'd0, mem_req_valid}, 32'd1);
      check("store wen", {31'd0, mem_wen}, 32'd1);
      check("store addr", mem_addr, 32'h200);
      check("store wdata", mem_wdata, 32'hDEAD_BEEF);
      check("store wstrb", {28'd0, mem_wstrb}, 32'h3);
      check("store data ready", {31'd0, data_req_ready}, 32'd1);
      check("store inst ready", {31'd0, inst_req_ready}, 32'd0);
      tick();
      data_wr = 1'b0; #1;
      check_quiet("store idle");
      tick(); #1;
      check("store stays idle", {31'd0, mem_req_valid}, 32'd0);

      // Simultaneous fetch and load with data priority
      inst_req_addr = 32'h104; inst_req_valid = 1'b1; inst_rready = 1'b1;
      data_addr = 32'h300; data_rd = 1'b1; data_rready = 1'b1;
      tick(); #1;
      check("tie data addr", mem_addr, 32'h300);
      check("tie data ready", {31'd0, data_req_ready}, 32'd1);
      check("tie inst waits", {31'd0, inst_req_ready}, 32'd0);
      check("load wstrb zero", {28'd0, mem_wstrb}, 32'd0);
      tick();
      data_rd = 1'b0; mem_rdata = 32'hCAFE_0001; mem_rvalid = 1'b1; #1;
      check("load rvalid", {31'd0, data_rvalid}, 32'd1);
      check("load rdata", data_rdata, 32'hCAFE_0001);
      check("load inst rvalid", {31'd0, inst_rvalid}, 32'd0);
      check("load inst ready", {31'd0, inst_req_ready}, 32'd0);
      tick();
      mem_rvalid = 1'b0; #1;
      check("gap idle", {31'd0, mem_req_valid}, 32'd0);
      tick(); #1;
      check("fetch after load addr", mem_addr, 32'h104);
      check("fetch after load ready", {31'd0, inst_req_ready}, 32'd1);
      tick();
      inst_req_valid = 1'b0; mem_rdata = 32'h0000_0093; mem_rvalid = 1'b1; #1;
      check("fetch after load rvalid", {31'd0, inst_rvalid}, 32'd1);
      tick();
      mem_rvalid = 1'b0;

      // Stall: mem_req_ready low for 5 cycles; stray rvalid and a late data request ignored
      mem_req_ready = 1'b0; inst_req_addr = 32'h108; inst_req_valid = 1'b1;
      tick();
      data_rd = 1'b1; data_addr = 32'h400; mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
      for (int c = 0; c < 5; c++) begin
         #1;
         check("stall valid", {31'd0, mem_req_valid}, 32'd1);
         check("stall addr", mem_addr, 32'h108);
         check("stall no ready", {30'd0, inst_req_ready, data_req_ready}, 32'd0);
         check("stall stray rvalid", {29'd0, inst_rvalid, data_rvalid, mem_rready}, 32'd0);
         tick();
      end
      mem_rvalid = 1'b0; mem_req_ready = 1'b1; #1;
      check("stall release ready", {31'd0, inst_req_ready}, 32'd1);
      tick();
      inst_req_valid = 1'b0; data_rd = 1'b0; #1;
      check("resp before reset", {31'd0, mem_rready}, 32'd1);

      // Reset asserted mid-RESP: outputs drop without a clock edge
      #2 rst = 1'b0;
      #1;
      check_quiet("async reset");
      check("rr async reset", {29'd0, rr_mem_req_valid, rr_mem_rready, rr_inst_req_ready}, 32'd0);
      tick();
      rst = 1'b1;
      do_fetch("post reset", 32'h10C, 32'h0000_0033);

      // Round-robin: both requesters pending continuously, fresh reset
      clear_inputs();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      inst_req_valid = 1'b1; inst_req_addr = 32'h500; inst_rready = 1'b1;
      data_rd = 1'b1; data_addr = 32'h600; data_rready = 1'b1; mem_req_ready = 1'b1;
      for (int t = 0; t < 4; t++) begin
         tick(); #1;
         check($sformatf("rr grant %0d data", t), {31'd0, rr_data_req_ready}, {31'd0, exp_order[t]});
         check($sformatf("rr grant %0d inst", t), {31'd0, rr_inst_req_ready}, {31'd0, ~exp_order[t]});
         check($sformatf("rr grant %0d addr", t), rr_mem_addr, exp_order[t] ? 32'h600 : 32'h500);
         tick();
         mem_rvalid = 1'b1; mem_rdata = 32'h1000 + t; #1;
         check($sformatf("rr resp %0d rready", t), {31'd0, rr_mem_rready}, 32'd1);
         tick();
         mem_rvalid = 1'b0;
      end
      clear_inputs();
      tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
